raster_engine: RTL and testbench
================================

// Module: raster_engine
// PURPOSE
//  GPU-side responder for the CPU->GPU raster command interface.
//  - Accepts one command per handshake (gpu_command, coordinates, colour, gpu_execute_request).
//  - Holds busy while it draws, writing one pixel per clock into the framebuffer write port.
//  - Sits between the CPU and the framebuffer RAM that the VGA scanout reads.
// PARAMETERS
//  FB_WIDTH   160  framebuffer width in pixels
//  FB_HEIGHT  120  framebuffer height in pixels
//  FB_ADDR_W  15   framebuffer address width, must satisfy 2**FB_ADDR_W >= FB_WIDTH*FB_HEIGHT
// PORTS
//  clk              in   1          system clock, 50MHz; single clock domain
//  rst_sync         in   1          synchronous reset, active-high
//  cmd              in   raster_command_t  command, sampled on accept
//  x0,y0,x1,y1      in   8 each     coordinates, unsigned, sampled on accept
//  colour           in   3          pixel colour, sampled on accept
//  execute_request  in   1          one-cycle request pulse; legal only while busy==0
//  busy             out  1          high from the cycle after accept until the cycle after the last write
//  fb_addr          out  FB_ADDR_W  write address, y*FB_WIDTH+x
//  fb_data          out  3          write colour
//  fb_we            out  1          write strobe, one pixel per cycle
// BEHAVIOUR
//  Reset:
//  - Next edge with rst_sync=1 -> state IDLE; busy=0, fb_we=0, fb_addr=0, fb_data=0.
//  - Reset mid-draw aborts immediately; no further writes.
//  States: IDLE -> SETUP -> DRAW -> IDLE.
//  Accept:
//  - In IDLE with execute_request=1, latch cmd/coords/colour at that edge (cycle N).
//  - busy=1 from N+1. Inputs are ignored thereafter.
//  - execute_request while busy is ignored. The bench flags it as a protocol error.
//  SETUP (cycle N+1), no write:
//  - Compute dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+-1, err=dx+dy.
//  - err is 11b signed; e2=2*err is 12b signed. Cursor x,y are 9b signed.
//  DRAW: first write at N+2, one write per cycle, no gaps.
//  - POINT: single write at (x0,y0).
//  - FILL: addr 0..FB_WIDTH*FB_HEIGHT-1 ascending, all colour; FB_WIDTH*FB_HEIGHT writes. Coordinates unused.
//  - LINE: Bresenham, all octants, endpoints inclusive; max(|dx|,|dy|)+1 writes.
//    Each cycle: write (x,y). If x==x1 && y==y1, finish.
//    Else e2=2*err; if e2>=dy {err+=dy; x+=sx}; if e2<=dx {err+=dx; y+=sy}.
//    When both conditions hold, both updates apply in the same cycle.
//    x0==x1 && y0==y1 gives exactly one write.
//  - Any other raster_command_t value: SETUP then IDLE, no writes, busy high for one cycle.
//  Clipping:
//  - A pixel with x>=FB_WIDTH or y>=FB_HEIGHT: cursor still steps and the cycle is consumed, but fb_we=0.
//  - Write count and cycle timing are unchanged by clipping.
//  Completion: last write at cycle L -> busy=0 at L+1. A new request is accepted at L+1 (back-to-back).
//  fb outputs:
//  - fb_we is high only in DRAW for on-screen pixels.
//  - fb_addr/fb_data are don't-care when fb_we=0.
//  - They are combinational from the registered cursor and latched colour; no extra pipeline stage.
// STRUCTURE
//  Package common:
//  - raster_command_t (FILL, POINT, LINE, ...).
//  - Add FB_WIDTH/FB_HEIGHT/FB_ADDR_W localparams so the scanout and this block share them.
//  Sub-module raster_line_stepper:
//  - Bresenham err/cursor regs, step and done.
//  - Reused by later rectangle and triangle commands.
//  Top:
//  - FSM, input latch, FILL address counter, clip check, address multiply by constant FB_WIDTH.
// TESTING
//  1. Reset, then POINT (100,100) colour 3'b110 at cycle N -> busy N+1..N+2; one write addr 16100 data 6 at N+2; busy=0 at N+3.
//  2. FILL colour 3'b101 -> 19200 writes, addr 0..19199 consecutive, all data 5; busy drops the cycle after addr 19199.
//  3. LINE (10,10)->(100,100) -> 91 writes, addrs 10*161+k*161 for k=0..90; repeat (100,100)->(10,10) -> same pixel set, reverse order.
//  4. LINE (0,0)->(7,3) and (3,0)->(0,7) -> pixels match a golden Bresenham model; 8 writes each.
//  5. LINE (150,5)->(170,5) -> 21 cycles in DRAW; writes only x=150..159; busy timing as if unclipped.
//  6. Reset asserted mid-FILL at addr 500 -> no writes after that edge; busy=0; next POINT request behaves as in test 1.

Source files
------------

// File: rtl/raster_engine_pkg.sv
// raster_engine_pkg: framebuffer geometry, command and FSM state types shared by the raster path and scanout
package raster_engine_pkg;
  localparam int FB_WIDTH = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_ADDR_W = 15;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  typedef enum logic [1:0] {CMD_FILL, CMD_POINT, CMD_LINE, CMD_NOP} raster_command_t;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} raster_state_t;
endpackage

// File: rtl/raster_engine_if.sv
// raster_engine_if: CPU command side (cmd, x0..y1, colour, execute_request, busy) and framebuffer write port (fb_addr, fb_data, fb_we)
interface raster_engine_if;
  import raster_engine_pkg::*;
  raster_command_t cmd;
  logic [7:0] x0, y0, x1, y1;
  logic [2:0] colour;
  logic execute_request;
  logic busy;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [2:0] fb_data;
  logic fb_we;
  modport master (output cmd, x0, y0, x1, y1, colour, execute_request, input busy, fb_addr, fb_data, fb_we);
  modport slave (input cmd, x0, y0, x1, y1, colour, execute_request, output busy, fb_addr, fb_data, fb_we);
endinterface

// File: rtl/raster_engine_line_stepper.sv
// raster_line_stepper: Bresenham cursor; load captures endpoints and deltas, step advances one pixel, done marks the end point
module raster_line_stepper (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [7:0]        x0,
  input  logic [7:0]        y0,
  input  logic [7:0]        x1,
  input  logic [7:0]        y1,
  output logic signed [8:0] x,
  output logic signed [8:0] y,
  output logic              done
);
  logic signed [10:0] dx, dy, err;
  logic signed [11:0] e2;
  logic [7:0] adx, ady, xe, ye;
  logic sx, sy, step_x, step_y;
  assign adx = x1 >= x0 ? x1 - x0 : x0 - x1;
  assign ady = y1 >= y0 ? y1 - y0 : y0 - y1;
  assign e2 = {err, 1'b0};
  assign step_x = e2 >= 12'(dy);
  assign step_y = e2 <= 12'(dx);
  assign done = x == $signed({1'b0, xe}) && y == $signed({1'b0, ye});
  always_ff @(posedge clk)
    if (rst) begin
      x <= '0;
      y <= '0;
      xe <= '0;
      ye <= '0;
      dx <= '0;
      dy <= '0;
      err <= '0;
      sx <= 1'b0;
      sy <= 1'b0;
    end else if (load) begin
      x <= $signed({1'b0, x0});
      y <= $signed({1'b0, y0});
      xe <= x1;
      ye <= y1;
      dx <= $signed({3'b0, adx});
      dy <= -$signed({3'b0, ady});
      err <= $signed({3'b0, adx}) - $signed({3'b0, ady});
      sx <= x1 < x0;
      sy <= y1 < y0;
    end else if (step && !done) begin
      err <= err + (step_x ? dy : 11'sd0) + (step_y ? dx : 11'sd0);
      x <= step_x ? (sx ? x - 9'sd1 : x + 9'sd1) : x;
      y <= step_y ? (sy ? y - 9'sd1 : y + 9'sd1) : y;
    end
endmodule

// File: rtl/raster_engine.sv
// raster_engine: accepts one raster command per handshake and writes one framebuffer pixel per clock while busy
// ports: clk, rst_sync (sync active-high), bus (raster_engine_if.slave: command in, busy and fb write port out)
module raster_engine
  import raster_engine_pkg::*;
(
  input logic            clk,
  input logic            rst_sync,
  raster_engine_if.slave bus
);
  raster_state_t state, state_n;
  raster_command_t cmd_q;
  logic [7:0] x0_q, y0_q, x1_q, y1_q;
  logic [2:0] colour_q;
  logic [FB_ADDR_W-1:0] fill_cnt, pix_addr;
  logic signed [8:0] cx, cy;
  logic line_done, last, on_screen;
  raster_line_stepper stepper (
    .clk(clk),
    .rst(rst_sync),
    .load(state == S_SETUP),
    .step(state == S_DRAW && cmd_q == CMD_LINE),
    .x0(x0_q),
    .y0(y0_q),
    .x1(x1_q),
    .y1(y1_q),
    .x(cx),
    .y(cy),
    .done(line_done)
  );
  // Off-screen cursor positions still consume a DRAW cycle; only the strobe is suppressed.
  assign on_screen = int'(cx) < FB_WIDTH && int'(cy) < FB_HEIGHT;
  assign pix_addr = FB_ADDR_W'(int'(cy[7:0]) * FB_WIDTH + int'(cx[7:0]));
  assign last = cmd_q == CMD_FILL ? fill_cnt == FB_ADDR_W'(FB_PIXELS - 1) : cmd_q == CMD_POINT ? 1'b1 : line_done;
  always_ff @(posedge clk) state <= rst_sync ? S_IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = bus.execute_request ? S_SETUP : S_IDLE;
      S_SETUP: state_n = cmd_q == CMD_NOP ? S_IDLE : S_DRAW;
      S_DRAW:  state_n = last ? S_IDLE : S_DRAW;
      default: state_n = S_IDLE;
    endcase
  end
  always_comb begin
    bus.busy = state != S_IDLE;
    bus.fb_we = state == S_DRAW && (cmd_q == CMD_FILL || on_screen);
    bus.fb_addr = cmd_q == CMD_FILL ? fill_cnt : pix_addr;
    bus.fb_data = colour_q;
  end
  always_ff @(posedge clk)
    if (rst_sync) begin
      cmd_q <= CMD_FILL;
      x0_q <= '0;
      y0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      colour_q <= '0;
    end else if (state == S_IDLE && bus.execute_request) begin
      cmd_q <= bus.cmd;
      x0_q <= bus.x0;
      y0_q <= bus.y0;
      x1_q <= bus.x1;
      y1_q <= bus.y1;
      colour_q <= bus.colour;
    end
  always_ff @(posedge clk) fill_cnt <= (rst_sync || state != S_DRAW) ? '0 : fill_cnt + 1'b1;
endmodule

// File: tb/tb_raster_engine.sv
// tb_raster_engine: scoreboard bench; a reference model queues expected pixel writes, a monitor checks every fb write
module tb_raster_engine;
  import raster_engine_pkg::*;
  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;
  logic clk = 1'b0;
  logic rst_sync = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  wr_t exp_q[$];
  wr_t e;
  raster_engine_if bus();
  raster_engine dut (
    .clk(clk),
    .rst_sync(rst_sync),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (bus.fb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0d data %0d at cycle %0d, expected no write", bus.fb_addr, bus.fb_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", int'(bus.fb_addr), e.addr);
        check("wr_data", int'(bus.fb_data), e.data);
        check("wr_cycle", cyc, e.cyc);
      end
    end
  always @(negedge clk)
    if (bus.execute_request === 1'b1 && bus.busy === 1'b1) begin
      tests++;
      fails++;
      $display("FAIL protocol: execute_request while busy at cycle %0d", cyc);
    end
  function automatic void emit(int x, int y, int col, int at);
    if (x >= 0 && x < FB_WIDTH && y >= 0 && y < FB_HEIGHT) exp_q.push_back('{y * FB_WIDTH + x, col, at});
  endfunction
  // Queues the expected writes for a command accepted during cycle n; returns its DRAW cycle count.
  function automatic int model(raster_command_t c, int x0, int y0, int x1, int y1, int col, int n);
    int x = x0;
    int y = y0;
    int dx = x1 > x0 ? x1 - x0 : x0 - x1;
    int dy = y1 > y0 ? y0 - y1 : y1 - y0;
    int sx = x0 < x1 ? 1 : -1;
    int sy = y0 < y1 ? 1 : -1;
    int err = dx + dy;
    int e2;
    int i = 0;
    if (c == CMD_FILL) begin
      for (int k = 0; k < FB_PIXELS; k++) exp_q.push_back('{k, col, n + 2 + k});
      return FB_PIXELS;
    end
    if (c == CMD_POINT) begin
      emit(x0, y0, col, n + 2);
      return 1;
    end
    if (c != CMD_LINE) return 0;
    forever begin
      emit(x, y, col, n + 2 + i);
      i++;
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin
        err += dy;
        x += sx;
      end
      if (e2 <= dx) begin
        err += dx;
        y += sy;
      end
    end
    return i;
  endfunction
  task automatic drive(raster_command_t c, int x0, int y0, int x1, int y1, int col);
    bus.cmd = c;
    bus.x0 = 8'(x0);
    bus.y0 = 8'(y0);
    bus.x1 = 8'(x1);
    bus.y1 = 8'(y1);
    bus.colour = 3'(col);
    bus.execute_request = 1'b1;
  endtask
  // Called at a negedge with the engine idle, so consecutive calls exercise back-to-back accepts.
  task automatic issue(raster_command_t c, int x0, int y0, int x1, int y1, int col);
    int draw;
    int cnt = 0;
    draw = model(c, x0, y0, x1, y1, col, cyc);
    drive(c, x0, y0, x1, y1, col);
    @(negedge clk);
    bus.execute_request = 1'b0;
    while (bus.busy === 1'b1 && cnt < 40000) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", cnt, draw + 1);
    check("writes_outstanding", exp_q.size(), 0);
    exp_q.delete();
  endtask
  initial begin
    int n;
    int r;
    raster_command_t c;
    bus.cmd = CMD_NOP;
    bus.x0 = '0;
    bus.y0 = '0;
    bus.x1 = '0;
    bus.y1 = '0;
    bus.colour = '0;
    bus.execute_request = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_fb_we", int'(bus.fb_we), 0);
    check("reset_fb_addr", int'(bus.fb_addr), 0);
    check("reset_fb_data", int'(bus.fb_data), 0);
    rst_sync = 1'b0;
    issue(CMD_POINT, 100, 100, 0, 0, 6);
    issue(CMD_FILL, 0, 0, 0, 0, 5);
    issue(CMD_LINE, 10, 10, 100, 100, 2);
    issue(CMD_LINE, 100, 100, 10, 10, 3);
    issue(CMD_LINE, 0, 0, 7, 3, 1);
    issue(CMD_LINE, 3, 0, 0, 7, 4);
    issue(CMD_LINE, 150, 5, 170, 5, 7);
    issue(CMD_LINE, 42, 17, 42, 17, 1);
    issue(CMD_NOP, 1, 2, 3, 4, 5);
    issue(CMD_LINE, 255, 200, 0, 0, 6);
    issue(CMD_POINT, 159, 119, 0, 0, 2);
    issue(CMD_POINT, 160, 50, 0, 0, 2);
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 3);
      c = r == 0 ? CMD_POINT : r == 3 ? CMD_NOP : CMD_LINE;
      issue(c, $urandom_range(0, 199), $urandom_range(0, 149), $urandom_range(0, 199), $urandom_range(0, 149), $urandom_range(0, 7));
    end
    n = cyc;
    void'(model(CMD_FILL, 0, 0, 0, 0, 3, n));
    drive(CMD_FILL, 0, 0, 0, 0, 3);
    @(negedge clk);
    bus.execute_request = 1'b0;
    while (cyc < n + 502) @(negedge clk);
    #2;
    rst_sync = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_fb_we", int'(bus.fb_we), 0);
    check("abort_fb_addr", int'(bus.fb_addr), 0);
    check("abort_fb_data", int'(bus.fb_data), 0);
    rst_sync = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_idle", int'(bus.busy), 0);
    issue(CMD_POINT, 100, 100, 0, 0, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
